// File: rtl/fir_pkg.sv
// Shared definitions for the FIR inverse filter: default coefficients, tap decode,
// FSM state encoding and the residual width rule.
package fir_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_A0    = 6;
   localparam int DEF_A1    = 5;
   localparam int DEF_A2    = 4;
   localparam int DEF_A3    = 3;
   localparam int DEF_A4    = 2;
   localparam int DEF_A5    = 1;

   localparam logic [2:0] TAP_MIN = 3'b010;
   localparam logic [2:0] TAP_MAX = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DIV  = 2'd2,
      ST_OUT  = 2'd3
   } fir_state_t;

   // Residual keeps 4 guard bits above the 2*width input so five tap subtractions never wrap.
   function automatic int rw_of(input int w);
      return 2 * w + 4;
   endfunction

   function automatic logic [2:0] decode_taps(input logic [2:0] tc);
      if (tc >= TAP_MIN && tc <= TAP_MAX) return tc;
      return TAP_MIN;
   endfunction

endpackage

// File: rtl/fir_inv_divider.sv
// Sequential restoring sign-magnitude divider: one quotient bit per cycle, truncating
// toward zero, remainder discarded.
module fir_inv_divider
   import fir_pkg::*;
#(
   parameter int RW = 36,
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic signed [RW-1:0] dividend,
   input  logic signed [DW-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic signed [RW-1:0] quotient
);

   localparam int CW = $clog2(RW + 1);

   logic [RW-1:0] q_reg;
   logic [DW-1:0] rem;
   logic [DW-1:0] dvs_mag;
   logic          neg;
   logic [CW-1:0] cnt;

   logic [RW-1:0] dividend_mag;
   logic [DW-1:0] divisor_mag;
   logic [DW:0]   trial;
   logic [DW:0]   rem_diff;
   logic          ge;
   logic [DW-1:0] rem_next;

   assign dividend_mag = dividend[RW-1] ? (~dividend + 1'b1) : dividend;
   assign divisor_mag  = divisor[DW-1] ? (~divisor + 1'b1) : divisor;

   assign trial    = {rem, q_reg[RW-1]};
   assign rem_diff = trial - {1'b0, dvs_mag};
   assign ge       = (trial >= {1'b0, dvs_mag});
   assign rem_next = ge ? rem_diff[DW-1:0] : trial[DW-1:0];

   assign quotient = neg ? (~q_reg + 1'b1) : q_reg;

   // q_reg starts as |dividend| and is shifted out while quotient bits shift in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg   <= '0;
         rem     <= '0;
         dvs_mag <= '0;
         neg     <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            q_reg   <= dividend_mag;
            rem     <= '0;
            dvs_mag <= divisor_mag;
            neg     <= dividend[RW-1] ^ divisor[DW-1];
            cnt     <= CW'(RW);
            busy    <= 1'b1;
         end else if (busy) begin
            q_reg <= {q_reg[RW-2:0], ge};
            rem   <= rem_next;
            cnt   <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fir_inverse_filter.sv
// Inverse filter for the 6-tap FIR: x[n] = (y[n] - sum a_k*x[n-k]) / a0 using own output history.
//
// state | meaning
// IDLE  | waiting for a sample; hist_clear zeroes history here
// ACC   | subtract one a_k*x[n-k] per cycle, k = 1..T-1
// DIV   | sequential divide of residual by a0
// OUT   | result held until out_ready, then history shifts
module fir_inverse_filter
   import fir_pkg::*;
#(
   parameter int                        width = DEF_WIDTH,
   parameter logic signed [width-1:0]   A0 = width'(DEF_A0),
   parameter logic signed [width-1:0]   A1 = width'(DEF_A1),
   parameter logic signed [width-1:0]   A2 = width'(DEF_A2),
   parameter logic signed [width-1:0]   A3 = width'(DEF_A3),
   parameter logic signed [width-1:0]   A4 = width'(DEF_A4),
   parameter logic signed [width-1:0]   A5 = width'(DEF_A5)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2*width-1:0]     in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             tap_control,
   input  logic                   hist_clear,
   output logic [width-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   sat
);

   localparam int RW = rw_of(width);
   localparam logic signed [RW-1:0] QMAX = {{(RW-width+1){1'b0}}, {(width-1){1'b1}}};
   localparam logic signed [RW-1:0] QMIN = {{(RW-width+1){1'b1}}, {(width-1){1'b0}}};

   fir_state_t state, state_next;

   logic signed [RW-1:0]      r;
   logic [2:0]                t_lat;
   logic [2:0]                k;
   logic signed [width-1:0]   hist [0:4];

   logic signed [width-1:0]   coef_sel;
   logic signed [width-1:0]   hist_sel;
   logic signed [2*width-1:0] prod;
   logic signed [RW-1:0]      acc_next;
   logic                      acc_last;
   logic                      accept;

   logic                      div_start;
   logic                      div_busy;
   logic                      div_done;
   logic signed [RW-1:0]      quotient;
   logic                      sat_hi;
   logic                      sat_lo;
   logic [width-1:0]          q_sat;

   assign in_ready = (state == ST_IDLE) && !hist_clear;
   assign accept   = in_valid && in_ready;

   always_comb begin
      coef_sel = '0;
      hist_sel = '0;
      case (k)
         3'd1: begin coef_sel = A1; hist_sel = hist[0]; end
         3'd2: begin coef_sel = A2; hist_sel = hist[1]; end
         3'd3: begin coef_sel = A3; hist_sel = hist[2]; end
         3'd4: begin coef_sel = A4; hist_sel = hist[3]; end
         3'd5: begin coef_sel = A5; hist_sel = hist[4]; end
         default: ;
      endcase
   end

   assign prod     = coef_sel * hist_sel;
   assign acc_next = r - $signed({{(RW-2*width){prod[2*width-1]}}, prod});
   assign acc_last = (k == t_lat - 3'd1);

   // The divider loads the residual as it leaves ACC, so the last subtraction feeds it directly.
   assign div_start = (state == ST_ACC) && acc_last && !div_busy;

   fir_inv_divider #(.RW(RW), .DW(width)) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (acc_next),
      .divisor  (A0),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quotient)
   );

   assign sat_hi = (quotient > QMAX);
   assign sat_lo = (quotient < QMIN);
   assign q_sat  = sat_hi ? {1'b0, {(width-1){1'b1}}} :
                   sat_lo ? {1'b1, {(width-1){1'b0}}} :
                            quotient[width-1:0];

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept)    state_next = ST_ACC;
         ST_ACC:  if (acc_last)  state_next = ST_DIV;
         ST_DIV:  if (div_done)  state_next = ST_OUT;
         ST_OUT:  if (out_ready) state_next = ST_IDLE;
         default:                state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r         <= '0;
         t_lat     <= TAP_MIN;
         k         <= 3'd1;
         out_data  <= '0;
         out_valid <= 1'b0;
         sat       <= 1'b0;
         for (int i = 0; i < 5; i++) hist[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hist_clear) begin
                  for (int i = 0; i < 5; i++) hist[i] <= '0;
               end else if (in_valid) begin
                  r     <= $signed({{(RW-2*width){in_data[2*width-1]}}, in_data});
                  t_lat <= decode_taps(tap_control);
                  k     <= 3'd1;
               end
            end
            ST_ACC: begin
               r <= acc_next;
               k <= k + 3'd1;
            end
            ST_DIV: begin
               if (div_done) begin
                  out_data  <= q_sat;
                  sat       <= sat_hi || sat_lo;
                  out_valid <= 1'b1;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  hist[0]   <= out_data;
                  for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Scoreboard bench for fir_inverse_filter: behavioural model of the deconvolution
// predicts each output at accept time; outputs are checked for value, sat and latency.
module tb_fir_inverse_filter;

   localparam int W  = 16;
   localparam int RW = 2 * W + 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [2*W-1:0]    in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        tap_control = 3'b010;
   logic              hist_clear = 1'b0;
   logic [W-1:0]      out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              sat;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [W-1:0] data;
      logic         sat;
      int           taps;
   } exp_t;
   exp_t sb[$];

   longint coef [0:5] = '{6, 5, 4, 3, 2, 1};
   longint mhist [0:4] = '{0, 0, 0, 0, 0};

   fir_inverse_filter dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .tap_control (tap_control),
      .hist_clear  (hist_clear),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sat         (sat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int model_taps(input logic [2:0] tc);
      case (tc)
         3'd2: return 2;
         3'd3: return 3;
         3'd4: return 4;
         3'd5: return 5;
         3'd6: return 6;
         default: return 2;
      endcase
   endfunction

   function automatic exp_t model_eval(input longint y, input logic [2:0] tc);
      exp_t   e;
      longint r;
      longint q;
      int     t;
      t = model_taps(tc);
      r = y;
      for (int i = 1; i < t; i++) r = r - coef[i] * mhist[i-1];
      q = r / coef[0];
      e.sat = 1'b0;
      if (q > 32767) begin
         q = 32767;
         e.sat = 1'b1;
      end else if (q < -32768) begin
         q = -32768;
         e.sat = 1'b1;
      end
      e.data = q[W-1:0];
      e.taps = t;
      return e;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 5; i++) mhist[i] = 0;
   endtask

   task automatic send(input longint y, input logic [2:0] tc, output int acc_edge);
      bit     done;
      exp_t   e;
      done = 0;
      acc_edge = -1;
      @(negedge clk);
      in_data     = y[2*W-1:0];
      tap_control = tc;
      in_valid    = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (in_ready) begin
            acc_edge = cyc + 1;
            e = model_eval(y, tc);
            sb.push_back(e);
            done = 1;
            @(posedge clk);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL send_accept: in_ready never high, required 1 (y=%0d)", y);
      end
   endtask

   task automatic recv(input int acc_edge, input int hold, input string name);
      bit   seen;
      int   lat;
      exp_t e;
      logic [W-1:0] first;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_timeout: out_valid never rose", name);
         return;
      end
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s_unexpected: output %0d with empty scoreboard", name, $signed(out_data));
         return;
      end
      e = sb.pop_front();
      lat = cyc - acc_edge;
      n_tests++;
      if (lat !== e.taps + RW) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, e.taps + RW);
      end
      n_tests++;
      if (out_data !== e.data || sat !== e.sat) begin
         n_fail++;
         $display("FAIL %s_data: got %0d sat=%b, required %0d sat=%b",
                  name, $signed(out_data), sat, $signed(e.data), e.sat);
      end
      first = out_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_tests++;
         if (out_data !== first || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_hold: data=%0d valid=%b in_ready=%b, required data=%0d valid=1 in_ready=0",
                     name, $signed(out_data), out_valid, in_ready, $signed(first));
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 4; i > 0; i--) mhist[i] = mhist[i-1];
      mhist[0] = longint'($signed(e.data));
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_after_handshake: valid=%b in_ready=%b, required valid=0 in_ready=1",
                  name, out_valid, in_ready);
      end
   endtask

   task automatic xfer(input longint y, input logic [2:0] tc, input string name);
      int a;
      send(y, tc, a);
      if (a >= 0) recv(a, 0, name);
   endtask

   task automatic do_hist_clear();
      @(negedge clk);
      hist_clear = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hist_clear_ready: in_ready=%b, required 0", in_ready);
      end
      @(negedge clk);
      hist_clear = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || sat !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b data=%0d sat=%b, required 0 0 0", out_valid, out_data, sat);
      end
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_t2_sequence();
      xfer(6,  3'b010, "t2_y6");
      xfer(17, 3'b010, "t2_y17");
      xfer(28, 3'b010, "t2_y28");
   endtask

   task automatic test_hist_clear();
      do_hist_clear();
      xfer(6, 3'b010, "clear_y6");
   endtask

   task automatic test_impulse();
      longint ys [0:5] = '{6, 5, 4, 3, 2, 1};
      do_hist_clear();
      foreach (ys[i]) xfer(ys[i], 3'b110, "impulse");
   endtask

   task automatic test_truncate_sat();
      do_hist_clear();
      xfer(-7, 3'b010, "trunc_neg7");
      xfer(40000 * 6, 3'b010, "sat_pos");
      xfer(-40000 * 6, 3'b010, "sat_neg");
   endtask

   task automatic test_tap_decode();
      int a;
      xfer(100, 3'b111, "tap_111");
      xfer(-50, 3'b000, "tap_000");
      xfer(1234, 3'b100, "tap_4");
      send(777, 3'b110, a);
      tap_control = 3'b010;
      repeat (2) @(negedge clk);
      tap_control = 3'b111;
      if (a >= 0) recv(a, 0, "tap_toggle");
   endtask

   task automatic test_backpressure();
      int a;
      send(-3000, 3'b011, a);
      if (a >= 0) recv(a, 10, "backpressure");
      xfer(500, 3'b101, "after_bp");
   endtask

   task automatic test_reset_mid_div();
      int a;
      send(999, 3'b010, a);
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || sat !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_div_outputs: valid=%b data=%0d sat=%b, required 0 0 0",
                  out_valid, out_data, sat);
      end
      sb.delete();
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_div_ready: got %b, required 1", in_ready);
      end
      repeat (45) @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_div_dropped: out_valid=%b, required 0", out_valid);
      end
      xfer(12, 3'b010, "post_reset_y12");
   endtask

   task automatic test_random();
      longint y;
      logic [2:0] tc;
      for (int i = 0; i < 8; i++) begin
         y  = longint'($signed($urandom_range(0, 400000))) - 200000;
         tc = 3'($urandom_range(0, 7));
         xfer(y, tc, "random");
      end
   endtask

   initial begin
      test_reset();
      test_t2_sequence();
      test_hist_clear();
      test_impulse();
      test_truncate_sat();
      test_tap_decode();
      test_backpressure();
      test_random();
      test_reset_mid_div();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
